cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbitrates functional-unit (FU) completion results onto the N_WAY-wide common data bus (CDB).
- The CDB drives complete_dest_tag / take_branch / br_result into the ROB, RS and map table.
- Up to N_OUT grants per cycle, round-robin fairness across N_FU requesters; output is registered (one-cycle latency).
- Flushes on branch_haz from the ROB retire stage.

Parameters:
N_FU, 6, number of FU result requesters
N_OUT, `N_WAY, CDB slots per cycle
TAG_W, `CDB_BITS, physical-register tag width
XLEN, `XLEN, data/branch-target width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
branch_haz  in  1  ROB flush; squash grants and CDB output
fu_valid  in  N_FU  FU holds a finished result
fu_tag  in  N_FU x TAG_W  destination tag; 0 = no destination
fu_take_branch  in  N_FU  branch resolved taken
fu_br_result  in  N_FU x XLEN  branch target
fu_grant  out  N_FU  combinational; result accepted this cycle
complete_dest_tag  out  N_OUT x TAG_W  CDB tag, 0 = idle slot
take_branch  out  N_OUT  CDB taken flag
br_result  out  N_OUT x XLEN  CDB branch target
cdb_valid  out  N_OUT  slot carries a result

Behaviour:
- Handshake:
  - FU asserts fu_valid with stable payload until the cycle fu_grant[i]=1.
  - Transfer occurs at that posedge; the FU may present a new result the following cycle.
  - fu_grant never asserts without fu_valid.
- Arbitration:
  - Scan FUs in order rr_ptr, rr_ptr+1, ... mod N_FU.
  - The first N_OUT valid requests with nonzero tag fill slots 0..N_OUT-1 in scan order.
- Tag-0 requests: granted in the same cycle they are seen, consume no slot, never broadcast.
- Latency: a result granted in cycle t appears on the CDB outputs in cycle t+1 for exactly one cycle.
- Unused slots drive tag 0, take_branch 0, br_result 0, cdb_valid 0.
- rr_ptr update:
  - ≥1 slot-consuming grant: rr_ptr <= (index of last slot-granted FU + 1) mod N_FU.
  - No slot-consuming grant: unchanged.
  - Wrap-around N_FU-1 -> 0 is required.
- Fewer valid requests than N_OUT: all are granted.
- More than N_OUT: the excess waits; a continuously-valid FU is granted within ceil(N_FU/N_OUT) cycles (starvation bound).
- branch_haz=1 in cycle t:
  - fu_grant = 0 in cycle t.
  - All CDB outputs are 0 in cycle t+1.
  - rr_ptr <= 0.
  - FUs are responsible for dropping squashed requests.
- Results registered in cycle t-1 are still broadcast in cycle t even if branch_haz=1 (the ROB ignores completions while branch_haz is high).
- Reset (also mid-operation):
  - All outputs 0, rr_ptr 0, fu_grant 0 during the reset cycle.
  - The registered CDB is cleared at the next posedge.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- Defined:
  - Extra output port fu_stall_cnt (N_FU x 16).
  - Per-FU saturating counter increments each cycle fu_valid[i] && !fu_grant[i].
  - Holds at 16'hFFFF; cleared by reset only (not by branch_haz).
- Undefined: port and counters absent; arbitration identical.

Decomposition:
- Shared package (sys_defs) holds CDB_PACKET typedef {tag, take_branch, br_result, valid} and the N_FU constant, so ROB/RS/map table consume one bus type.
- Natural sub-module: rr_multi_grant.
  - Combinational: inputs req vector, ptr, N_OUT.
  - Outputs grant vector, per-slot one-hot select, next_ptr.
- cdb_arbiter adds the tag-0 bypass, output registers, flush and stats.

Test Plan:
- Reset then idle -> all CDB outputs 0, fu_grant 0, rr_ptr 0.
- N_OUT=2, fu_valid=6'b000101, tags 5 and 9 -> fu_grant=000101 same cycle; next cycle slot0 tag 5, slot1 tag 9, cdb_valid=11; rr_ptr=3.
- All 6 FUs valid continuously, rr_ptr=0 -> grants {0,1}, {2,3}, {4,5}, {0,1} on successive cycles; no FU waits more than 3 cycles.
- fu_valid=6'b100000 tag 0 plus FU1 tag 7 -> both granted; next cycle only slot0 tag 7 valid, slot1 idle; rr_ptr=2.
- FU2 branch tag 12, take_branch 1, br_result 32'h0000_1040 granted; branch_haz raised the following cycle -> tag 12 broadcast that cycle, fu_grant=0, CDB all 0 after, rr_ptr=0.
- With CDB_ARB_STATS_EN: FU5 held valid 4 cycles behind higher-priority FUs -> fu_stall_cnt[5]=4 after grant; remains 4 after branch_haz.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB bus type and arbiter constants consumed by the ROB, RS and map table.
// No logic; widths default from the machine-wide macros when the build does not supply them.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

  localparam int N_FU      = 6;
  localparam int CDB_TAG_W = `CDB_BITS;
  localparam int CDB_XLEN  = `XLEN;

  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic                 take_branch;
    logic [CDB_XLEN-1:0]  br_result;
    logic                 valid;
  } CDB_PACKET;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Round-robin multi-grant: picks up to N_SLOT requesters starting at ptr, fills slots in scan order.
// Latency: purely combinational. Backpressure: requests beyond N_SLOT are left ungranted.
// next_ptr points just past the last slot-granted requester, or holds when nothing is granted.
module cdb_arbiter_rr_multi_grant
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 6,
  parameter int N_SLOT = 2,
  parameter int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [PTR_W-1:0]             ptr,
  output logic [N_REQ-1:0]             grant,
  output logic [N_SLOT-1:0][N_REQ-1:0] slot_sel,
  output logic [PTR_W-1:0]             next_ptr
);

  int idx;
  int used;

  always_comb begin
    grant    = '0;
    slot_sel = '0;
    next_ptr = ptr;
    idx      = 0;
    used     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx] && (used < N_SLOT)) begin
        grant[idx]          = 1'b1;
        slot_sel[used][idx] = 1'b1;
        used                = used + 1;
        next_ptr            = PTR_W'(wrap_inc(idx, N_REQ));
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates FU completions onto the N_OUT-slot CDB with round-robin fairness; tag-0 results bypass.
// Latency: grant combinational, CDB registered (1 cycle). Backpressure: ungranted FUs hold fu_valid.
// Optional per-FU stall counters (fu_stall_cnt) exist only when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
  parameter int N_FU  = cdb_arbiter_pkg::N_FU,
  parameter int N_OUT = `N_WAY,
  parameter int TAG_W = `CDB_BITS,
  parameter int XLEN  = `XLEN
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        branch_haz,
  input  logic [N_FU-1:0]             fu_valid,
  input  logic [N_FU-1:0][TAG_W-1:0]  fu_tag,
  input  logic [N_FU-1:0]             fu_take_branch,
  input  logic [N_FU-1:0][XLEN-1:0]   fu_br_result,
  output logic [N_FU-1:0]             fu_grant,
  output logic [N_OUT-1:0][TAG_W-1:0] complete_dest_tag,
  output logic [N_OUT-1:0]            take_branch,
  output logic [N_OUT-1:0][XLEN-1:0]  br_result,
  output logic [N_OUT-1:0]            cdb_valid
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_FU-1:0][15:0]       fu_stall_cnt
`endif
);

  import cdb_arbiter_pkg::*;

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           next_ptr;
  logic                       arb_en;
  logic [N_FU-1:0]            tag_nz;
  logic [N_FU-1:0]            slot_req;
  logic [N_FU-1:0]            slot_grant;
  logic [N_FU-1:0]            bypass_grant;
  logic [N_OUT-1:0][N_FU-1:0] slot_sel;
  CDB_PACKET [N_OUT-1:0]      cdb_d;
  CDB_PACKET [N_OUT-1:0]      cdb_q;

  // Flush and reset both squash the whole grant vector, including tag-0 bypasses.
  assign arb_en = !reset && !branch_haz;

  always_comb begin
    tag_nz = '0;
    for (int i = 0; i < N_FU; i++) begin
      tag_nz[i] = |fu_tag[i];
    end
  end

  assign slot_req     = fu_valid & tag_nz & {N_FU{arb_en}};
  assign bypass_grant = fu_valid & ~tag_nz & {N_FU{arb_en}};
  assign fu_grant     = slot_grant | bypass_grant;

  cdb_arbiter_rr_multi_grant #(
    .N_REQ  (N_FU),
    .N_SLOT (N_OUT),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req      (slot_req),
    .ptr      (rr_ptr),
    .grant    (slot_grant),
    .slot_sel (slot_sel),
    .next_ptr (next_ptr)
  );

  always_comb begin
    cdb_d = '0;
    for (int s = 0; s < N_OUT; s++) begin
      for (int i = 0; i < N_FU; i++) begin
        if (slot_sel[s][i]) begin
          cdb_d[s].tag         = fu_tag[i];
          cdb_d[s].take_branch = fu_take_branch[i];
          cdb_d[s].br_result   = fu_br_result[i];
          cdb_d[s].valid       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || branch_haz) begin
      cdb_q  <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_q  <= cdb_d;
      rr_ptr <= next_ptr;
    end
  end

  always_comb begin
    for (int s = 0; s < N_OUT; s++) begin
      complete_dest_tag[s] = cdb_q[s].tag;
      take_branch[s]       = cdb_q[s].take_branch;
      br_result[s]         = cdb_q[s].br_result;
      cdb_valid[s]         = cdb_q[s].valid;
    end
  end

`ifdef CDB_ARB_STATS_EN
  // Saturating; a flush does not clear history, only reset does.
  always_ff @(posedge clock) begin
    if (reset) begin
      fu_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (fu_valid[i] && !fu_grant[i] && (fu_stall_cnt[i] != 16'hFFFF)) begin
          fu_stall_cnt[i] <= fu_stall_cnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
